alu_exec: RTL and testbench

- Execution unit that receives the reservation-station issue bundle (exe_* signals) and returns results on the ALU result broadcast (alu_valid / alu_rob_id / alu_data).
- The broadcast is consumed by the RS, LSB and ROB wakeup/commit logic.
- Pipelined with fixed latency and no backpressure: it accepts one operation every cycle.
- Also resolves branches and jumps (taken flag plus target) for the ROB.

---
 rtl/alu_exec_pkg.sv | 75 +++++++
 rtl/alu_core.sv | 53 +++++
 rtl/alu_exec.sv | 169 ++++++++++++++++
 tb/tb_alu_exec.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants, result payload and compute helpers for the ALU execution unit.
package alu_exec_pkg;

   localparam int unsigned DATA_WID   = 32;
   localparam int unsigned ADDR_WID   = 32;
   localparam int unsigned ROB_ID_WID = 4;

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef struct packed {
      logic [DATA_WID-1:0] data;
      logic                jump;
      logic [ADDR_WID-1:0] target;
   } alu_res_t;

   // Integer op selected by funct3; alt picks SUB over ADD and SRA over SRL.
   function automatic logic [DATA_WID-1:0] alu_arith(input logic [2:0]          f3,
                                                     input logic                alt,
                                                     input logic [DATA_WID-1:0] a,
                                                     input logic [DATA_WID-1:0] b);
      logic [DATA_WID-1:0] y;
      logic [4:0]          sh;
      sh = b[4:0];
      case (f3)
         F3_ADD:  y = alt ? a - b : a + b;
         F3_SLL:  y = a << sh;
         F3_SLT:  y = DATA_WID'($signed(a) < $signed(b));
         F3_SLTU: y = DATA_WID'(a < b);
         F3_XOR:  y = a ^ b;
         F3_SR:   y = alt ? $unsigned($signed(a) >>> sh) : a >> sh;
         F3_OR:   y = a | b;
         default: y = a & b;
      endcase
      return y;
   endfunction

   function automatic logic br_taken(input logic [2:0]          f3,
                                     input logic [DATA_WID-1:0] a,
                                     input logic [DATA_WID-1:0] b);
      logic t;
      case (f3)
         F3_BEQ:  t = (a == b);
         F3_BNE:  t = (a != b);
         F3_BLT:  t = ($signed(a) < $signed(b));
         F3_BGE:  t = ($signed(a) >= $signed(b));
         F3_BLTU: t = (a < b);
         F3_BGEU: t = (a >= b);
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational decode and compute: writeback value, taken flag and resolved target.
module alu_core
   import alu_exec_pkg::*;
(
   input  logic [6:0]          opcode,
   input  logic [2:0]          func3,
   input  logic                func1,
   input  logic [DATA_WID-1:0] data1,
   input  logic [DATA_WID-1:0] data2,
   input  logic [DATA_WID-1:0] imm,
   input  logic [DATA_WID-1:0] off,
   input  logic [ADDR_WID-1:0] pc,
   output alu_res_t            res_c
);

   logic [ADDR_WID-1:0] pc_seq_c;
   logic [ADDR_WID-1:0] pc_off_c;
   logic [ADDR_WID-1:0] jalr_sum_c;
   logic                taken_c;

   assign pc_seq_c   = pc + ADDR_WID'(4);
   assign pc_off_c   = pc + off;
   assign jalr_sum_c = data1 + imm;
   assign taken_c    = br_taken(func3, data1, data2);

   // Unknown opcodes fall through to an all-zero result so the ROB slot still completes.
   always_comb begin
      res_c = '0;
      case (opcode)
         OPC_LUI:   res_c.data = imm;
         OPC_AUIPC: res_c.data = pc + imm;
         OPC_OPIMM: res_c.data = alu_arith(func3, func1 & (func3 == F3_SR), data1, imm);
         OPC_OP:    res_c.data = alu_arith(func3, func1, data1, data2);
         OPC_JAL: begin
            res_c.data   = pc_seq_c;
            res_c.jump   = 1'b1;
            res_c.target = pc_off_c;
         end
         OPC_JALR: begin
            res_c.data   = pc_seq_c;
            res_c.jump   = 1'b1;
            res_c.target = {jalr_sum_c[ADDR_WID-1:1], 1'b0};
         end
         OPC_BR: begin
            res_c.data   = DATA_WID'(taken_c);
            res_c.jump   = taken_c;
            res_c.target = taken_c ? pc_off_c : pc_seq_c;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_exec.sv
// Pipelined ALU execution unit with flush, global stall and result broadcast.
// Optional op/taken counters are built when ALU_STATS_EN is defined.
module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int unsigned PIPE_STAGES = 1,
   parameter int unsigned ROB_ID_W    = ROB_ID_WID
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rdy,
   input  logic                rollback,
   input  logic                exe_valid,
   input  logic [6:0]          exe_opcode,
   input  logic [2:0]          exe_func3,
   input  logic                exe_func1,
   input  logic [31:0]         exe_data1,
   input  logic [31:0]         exe_data2,
   input  logic [31:0]         exe_imm,
   input  logic [31:0]         exe_off,
   input  logic [31:0]         exe_pc,
   input  logic [ROB_ID_W-1:0] exe_rob_target,
   output logic                alu_valid,
   output logic [ROB_ID_W-1:0] alu_rob_id,
   output logic [31:0]         alu_data,
   output logic                alu_jump,
   output logic [31:0]         alu_target,
   output logic [31:0]         stat_ops,
   output logic [31:0]         stat_br_taken
);

   alu_res_t core_res_c;

   alu_core u_core (
      .opcode (exe_opcode),
      .func3  (exe_func3),
      .func1  (exe_func1),
      .data1  (exe_data1),
      .data2  (exe_data2),
      .imm    (exe_imm),
      .off    (exe_off),
      .pc     (exe_pc),
      .res_c  (core_res_c)
   );

   logic                s1_valid_q, s1_valid_d;
   logic [ROB_ID_W-1:0] s1_rob_q,   s1_rob_d;
   alu_res_t            s1_res_q,   s1_res_d;

   // Payload only reloads on an accepted issue so it holds while the valid bit is low.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_rob_d   = s1_rob_q;
      s1_res_d   = s1_res_q;
      if (rollback) begin
         s1_valid_d = 1'b0;
      end else if (rdy) begin
         s1_valid_d = exe_valid;
         if (exe_valid) begin
            s1_rob_d = exe_rob_target;
            s1_res_d = core_res_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_rob_q   <= '0;
         s1_res_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_rob_q   <= s1_rob_d;
         s1_res_q   <= s1_res_d;
      end
   end

`ifdef ALU_STATS_EN
   logic out_load_c;
   logic out_jump_in_c;
`endif

   generate
      if (PIPE_STAGES == 2) begin : g_two
         logic                s2_valid_q, s2_valid_d;
         logic [ROB_ID_W-1:0] s2_rob_q,   s2_rob_d;
         alu_res_t            s2_res_q,   s2_res_d;

         always_comb begin
            s2_valid_d = s2_valid_q;
            s2_rob_d   = s2_rob_q;
            s2_res_d   = s2_res_q;
            if (rollback) begin
               s2_valid_d = 1'b0;
            end else if (rdy) begin
               s2_valid_d = s1_valid_q;
               if (s1_valid_q) begin
                  s2_rob_d = s1_rob_q;
                  s2_res_d = s1_res_q;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_valid_q <= 1'b0;
               s2_rob_q   <= '0;
               s2_res_q   <= '0;
            end else begin
               s2_valid_q <= s2_valid_d;
               s2_rob_q   <= s2_rob_d;
               s2_res_q   <= s2_res_d;
            end
         end

         assign alu_valid  = s2_valid_q;
         assign alu_rob_id = s2_rob_q;
         assign alu_data   = s2_res_q.data;
         assign alu_jump   = s2_res_q.jump;
         assign alu_target = s2_res_q.target;
`ifdef ALU_STATS_EN
         assign out_load_c    = rdy & ~rollback & s1_valid_q;
         assign out_jump_in_c = s1_res_q.jump;
`endif
      end else begin : g_one
         assign alu_valid  = s1_valid_q;
         assign alu_rob_id = s1_rob_q;
         assign alu_data   = s1_res_q.data;
         assign alu_jump   = s1_res_q.jump;
         assign alu_target = s1_res_q.target;
`ifdef ALU_STATS_EN
         assign out_load_c    = rdy & ~rollback & exe_valid;
         assign out_jump_in_c = core_res_c.jump;
`endif
      end
   endgenerate

`ifdef ALU_STATS_EN
   logic [31:0] ops_q, ops_d;
   logic [31:0] br_q,  br_d;

   // Counted as a result enters the output stage, so flushed ops never count.
   always_comb begin
      ops_d = ops_q;
      br_d  = br_q;
      if (out_load_c) begin
         ops_d = ops_q + 32'd1;
         if (out_jump_in_c) br_d = br_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops_q <= '0;
         br_q  <= '0;
      end else begin
         ops_q <= ops_d;
         br_q  <= br_d;
      end
   end

   assign stat_ops      = ops_q;
   assign stat_br_taken = br_q;
`else
   assign stat_ops      = '0;
   assign stat_br_taken = '0;
`endif

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench: one- and two-stage instances driven in parallel against a reference model.
module tb_alu_exec;

`ifdef ALU_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic        v;
      logic [3:0]  rob;
      logic [31:0] data;
      logic        jump;
      logic [31:0] tgt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, rdy, rollback, exe_valid, exe_func1;
   logic [6:0]  exe_opcode;
   logic [2:0]  exe_func3;
   logic [31:0] exe_data1, exe_data2, exe_imm, exe_off, exe_pc;
   logic [3:0]  exe_rob;

   logic        o1_valid, o1_jump, o2_valid, o2_jump;
   logic [3:0]  o1_rob, o2_rob;
   logic [31:0] o1_data, o1_tgt, o1_ops, o1_br, o2_data, o2_tgt, o2_ops, o2_br;

   int checks = 0;
   int errors = 0;

   exp_t        m1;
   exp_t        m2 [2];
   logic [31:0] c1_ops, c1_br, c2_ops, c2_br;

   always #5 clk = ~clk;

   alu_exec #(.PIPE_STAGES(1), .ROB_ID_W(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback), .exe_valid(exe_valid),
      .exe_opcode(exe_opcode), .exe_func3(exe_func3), .exe_func1(exe_func1),
      .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_imm(exe_imm), .exe_off(exe_off),
      .exe_pc(exe_pc), .exe_rob_target(exe_rob),
      .alu_valid(o1_valid), .alu_rob_id(o1_rob), .alu_data(o1_data), .alu_jump(o1_jump),
      .alu_target(o1_tgt), .stat_ops(o1_ops), .stat_br_taken(o1_br));

   alu_exec #(.PIPE_STAGES(2), .ROB_ID_W(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback), .exe_valid(exe_valid),
      .exe_opcode(exe_opcode), .exe_func3(exe_func3), .exe_func1(exe_func1),
      .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_imm(exe_imm), .exe_off(exe_off),
      .exe_pc(exe_pc), .exe_rob_target(exe_rob),
      .alu_valid(o2_valid), .alu_rob_id(o2_rob), .alu_data(o2_data), .alu_jump(o2_jump),
      .alu_target(o2_tgt), .stat_ops(o2_ops), .stat_br_taken(o2_br));

   // Architectural result of one instruction, straight from the ISA rules.
   function automatic exp_t ref_exec(input logic [6:0] opc, input logic [2:0] f3, input logic f1,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] imm, input logic [31:0] off,
                                     input logic [31:0] pc);
      exp_t        r;
      logic [31:0] y;
      logic [63:0] ext;
      logic        t;
      r = '0;
      y = (opc == 7'b0010011) ? imm : b;
      ext = {{32{a[31]}}, a};
      t = 1'b0;
      case (opc)
         7'b0110111: r.data = imm;
         7'b0010111: r.data = pc + imm;
         7'b0010011, 7'b0110011: begin
            case (f3)
               3'd0: r.data = (opc == 7'b0110011 && f1) ? a - y : a + y;
               3'd1: r.data = a << y[4:0];
               3'd2: r.data = (int'(a) < int'(y)) ? 32'd1 : 32'd0;
               3'd3: r.data = (a < y) ? 32'd1 : 32'd0;
               3'd4: r.data = a ^ y;
               3'd5: r.data = f1 ? ext[31:0] >> 0 : a >> y[4:0];
               3'd6: r.data = a | y;
               default: r.data = a & y;
            endcase
            if (f3 == 3'd5 && f1) begin
               ext = ext >> y[4:0];
               r.data = ext[31:0];
            end
         end
         7'b1101111: begin r.data = pc + 32'd4; r.jump = 1'b1; r.tgt = pc + off; end
         7'b1100111: begin r.data = pc + 32'd4; r.jump = 1'b1; r.tgt = (a + imm) & 32'hFFFF_FFFE; end
         7'b1100011: begin
            case (f3)
               3'd0: t = (a == b);
               3'd1: t = (a != b);
               3'd4: t = (int'(a) < int'(b));
               3'd5: t = (int'(a) >= int'(b));
               3'd6: t = (a < b);
               3'd7: t = (a >= b);
               default: t = 1'b0;
            endcase
            r.data = t ? 32'd1 : 32'd0;
            r.jump = t;
            r.tgt  = t ? pc + off : pc + 32'd4;
         end
         default: ;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m1 = '0; m2[0] = '0; m2[1] = '0;
      c1_ops = '0; c1_br = '0; c2_ops = '0; c2_br = '0;
   endtask

   task automatic model_edge();
      exp_t nw;
      if (rollback) begin
         m1.v = 1'b0; m2[0].v = 1'b0; m2[1].v = 1'b0;
      end else if (rdy) begin
         nw = ref_exec(exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2, exe_imm, exe_off, exe_pc);
         nw.v = exe_valid;
         nw.rob = exe_rob;
         m2[1] = m2[0];
         m2[0] = nw;
         m1 = nw;
         if (m1.v) begin c1_ops = c1_ops + 32'd1; if (m1.jump) c1_br = c1_br + 32'd1; end
         if (m2[1].v) begin c2_ops = c2_ops + 32'd1; if (m2[1].jump) c2_br = c2_br + 32'd1; end
      end
   endtask

   task automatic compare_all();
      chk("valid1", 32'(o1_valid), 32'(m1.v));
      if (m1.v) begin
         chk("rob1", 32'(o1_rob), 32'(m1.rob));
         chk("data1", o1_data, m1.data);
         chk("jump1", 32'(o1_jump), 32'(m1.jump));
         if (m1.jump) chk("tgt1", o1_tgt, m1.tgt);
      end
      chk("valid2", 32'(o2_valid), 32'(m2[1].v));
      if (m2[1].v) begin
         chk("rob2", 32'(o2_rob), 32'(m2[1].rob));
         chk("data2", o2_data, m2[1].data);
         chk("jump2", 32'(o2_jump), 32'(m2[1].jump));
         if (m2[1].jump) chk("tgt2", o2_tgt, m2[1].tgt);
      end
      chk("ops1", o1_ops, STATS ? c1_ops : 32'd0);
      chk("br1",  o1_br,  STATS ? c1_br  : 32'd0);
      chk("ops2", o2_ops, STATS ? c2_ops : 32'd0);
      chk("br2",  o2_br,  STATS ? c2_br  : 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic f1,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [31:0] off, input logic [31:0] pc, input logic [3:0] rob);
      exe_valid = 1'b1; exe_opcode = opc; exe_func3 = f3; exe_func1 = f1;
      exe_data1 = d1; exe_data2 = d2; exe_imm = imm; exe_off = off; exe_pc = pc; exe_rob = rob;
   endtask

   task automatic idle();
      exe_valid = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_v1"}, 32'(o1_valid), 32'd0);
      chk({tag, "_d1"}, o1_data, 32'd0);
      chk({tag, "_t1"}, o1_tgt, 32'd0);
      chk({tag, "_j1"}, 32'(o1_jump), 32'd0);
      chk({tag, "_r1"}, 32'(o1_rob), 32'd0);
      chk({tag, "_v2"}, 32'(o2_valid), 32'd0);
      chk({tag, "_d2"}, o2_data, 32'd0);
      chk({tag, "_s1"}, o1_ops, 32'd0);
      chk({tag, "_s2"}, o2_br, 32'd0);
   endtask

   logic [6:0] opc_tab [8];

   initial begin
      opc_tab[0] = 7'b0110111; opc_tab[1] = 7'b0010111; opc_tab[2] = 7'b0010011;
      opc_tab[3] = 7'b0110011; opc_tab[4] = 7'b1101111; opc_tab[5] = 7'b1100111;
      opc_tab[6] = 7'b1100011; opc_tab[7] = 7'b0000000;

      rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0;
      issue(7'd0, 3'd0, 1'b0, '0, '0, '0, '0, '0, 4'd0);
      idle();
      model_reset();
      #2;
      chk_zero("reset");
      #1 rst_n = 1'b1;

      // ADD then SUB back-to-back
      issue(7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, '0, '0, '0, 4'd3);
      step();
      chk("add_data", o1_data, 32'd12);
      issue(7'b0110011, 3'd0, 1'b1, 32'd5, 32'd7, '0, '0, '0, 4'd4);
      step();
      chk("sub_data", o1_data, 32'hFFFF_FFFE);
      chk("sub_rob", 32'(o1_rob), 32'd4);
      chk("add_data_p2", o2_data, 32'd12);
      chk("add_rob_p2", 32'(o2_rob), 32'd3);

      // Shift immediates and ADDI ignoring func1
      issue(7'b0010011, 3'd5, 1'b1, 32'h8000_0000, '0, 32'd4, '0, '0, 4'd5);
      step();
      chk("srai", o1_data, 32'hF800_0000);
      chk("sub_data_p2", o2_data, 32'hFFFF_FFFE);
      issue(7'b0010011, 3'd5, 1'b0, 32'h8000_0000, '0, 32'd4, '0, '0, 4'd6);
      step();
      chk("srli", o1_data, 32'h0800_0000);
      issue(7'b0010011, 3'd0, 1'b1, 32'h8000_0000, '0, 32'd1, '0, '0, 4'd7);
      step();
      chk("addi_f1", o1_data, 32'h8000_0001);

      // Signed vs unsigned branch, then JALR
      issue(7'b1100011, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, '0, 32'h20, 32'h100, 4'd8);
      step();
      chk("blt_j", 32'(o1_jump), 32'd1);
      chk("blt_t", o1_tgt, 32'h120);
      chk("blt_d", o1_data, 32'd1);
      issue(7'b1100011, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, '0, 32'h20, 32'h100, 4'd9);
      step();
      chk("bltu_j", 32'(o1_jump), 32'd0);
      chk("bltu_t", o1_tgt, 32'h104);
      chk("bltu_d", o1_data, 32'd0);
      issue(7'b1100111, 3'd0, 1'b0, 32'h1003, '0, 32'h10, '0, 32'h200, 4'd10);
      step();
      chk("jalr_d", o1_data, 32'h204);
      chk("jalr_t", o1_tgt, 32'h1012);
      chk("jalr_j", 32'(o1_jump), 32'd1);
      idle();
      step();
      step();

      // Rollback one cycle after issue; the issue alongside the rollback is dropped
      issue(7'b0110111, 3'd0, 1'b0, '0, '0, 32'hABCD_0000, '0, '0, 4'd1);
      step();
      rollback = 1'b1;
      issue(7'b0110111, 3'd0, 1'b0, '0, '0, 32'h1234_0000, '0, '0, 4'd2);
      step();
      chk("flush_v2_a", 32'(o2_valid), 32'd0);
      chk("flush_v1_a", 32'(o1_valid), 32'd0);
      rollback = 1'b0;
      idle();
      step();
      chk("flush_v2_b", 32'(o2_valid), 32'd0);
      step();

      // Stall with a result pending
      issue(7'b0110011, 3'd4, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, '0, '0, '0, 4'd11);
      step();
      rdy = 1'b0;
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_v1", 32'(o1_valid), 32'd1);
         chk("hold_d1", o1_data, 32'h0000_FF00);
         chk("hold_v2", 32'(o2_valid), 32'd0);
      end
      rdy = 1'b1;
      step();
      chk("rel_v2", 32'(o2_valid), 32'd1);
      chk("rel_d2", o2_data, 32'h0000_FF00);
      chk("rel_v1", 32'(o1_valid), 32'd0);

      // Asynchronous reset mid-stream
      issue(7'b0110011, 3'd0, 1'b0, 32'd1, 32'd2, '0, '0, '0, 4'd12);
      step();
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      model_reset();
      #1 rst_n = 1'b1;

      // Three ops, one taken branch
      issue(7'b0110011, 3'd0, 1'b0, 32'd3, 32'd4, '0, '0, '0, 4'd1);
      step();
      issue(7'b1100011, 3'd0, 1'b0, 32'd9, 32'd9, '0, 32'h40, 32'h300, 4'd2);
      step();
      issue(7'b0110011, 3'd0, 1'b1, 32'd9, 32'd4, '0, '0, '0, 4'd3);
      step();
      idle();
      step();
      chk("stat_ops", o1_ops, STATS ? 32'd3 : 32'd0);
      chk("stat_br", o1_br, STATS ? 32'd1 : 32'd0);
      chk("stat_ops2", o2_ops, STATS ? 32'd3 : 32'd0);
      chk("stat_br2", o2_br, STATS ? 32'd1 : 32'd0);

      // Randomized traffic with stalls and flushes
      for (int n = 0; n < 400; n++) begin
         rdy = ($urandom_range(0, 9) != 0);
         rollback = ($urandom_range(0, 19) == 0);
         exe_valid = ($urandom_range(0, 3) != 0);
         exe_opcode = opc_tab[$urandom_range(0, 7)];
         exe_func3 = 3'($urandom_range(0, 7));
         exe_func1 = 1'($urandom_range(0, 1));
         exe_data1 = $urandom;
         exe_data2 = ($urandom_range(0, 3) == 0) ? exe_data1 : $urandom;
         exe_imm = $urandom;
         exe_off = $urandom;
         exe_pc = $urandom;
         exe_rob = 4'($urandom_range(0, 15));
         step();
      end
      rdy = 1'b1; rollback = 1'b0; idle();
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
